itcm_arb: RTL and testbench

Arbiter that shares the single-port, dual-bank ITCM between the instruction-fetch port and the load/store port. Each cycle it grants at most one requester and drives the ITCM control lines. It returns read data one cycle later, routed to the owner of the access. Load/store has default priority; a saturating starvation counter guarantees fetch forward progress. The block sits between the core's fetch/LSU request ports and the ITCM macro. The caller has already decoded the LSU request as an ITCM-region access.

---
 rtl/itcm_arb_if.sv | 40 ++++
 rtl/itcm_arb.sv | 129 ++++++++++++
 tb/tb_itcm_arb.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/itcm_arb_if.sv
// Bundles the fetch port, load/store port and ITCM macro lines that meet at itcm_arb.
// The arbiter takes the slave view; the core/macro side (or a bench) takes the master view.
interface itcm_arb_if #(
    parameter int AW = 16
);
    logic          if_req;
    logic [28:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [63:0]   if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [31:0]   ls_addr;
    logic [3:0]    ls_ben;
    logic [31:0]   ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [31:0]   ls_rdata;

    logic          ram_csn0;
    logic          ram_csn1;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_ben;
    logic [63:0]   ram_din;
    logic [63:0]   ram_dout;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_ben, ls_wdata, ram_dout,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               ram_csn0, ram_csn1, ram_wen, ram_addr, ram_ben, ram_din
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_ben, ls_wdata, ram_dout,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               ram_csn0, ram_csn1, ram_wen, ram_addr, ram_ben, ram_din
    );
endinterface

// File: rtl/itcm_arb.sv
// Shares the single-port, dual-lane ITCM between instruction fetch and load/store.
// Load/store has priority; a saturating starvation counter lets fetch through.
module itcm_arb #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      cpurst_n,
    itcm_arb_if.slave bus
);
    // Width floor of 1 keeps STARVE_MAX = 0 legal (counter then sits at 0 = fetch always wins).
    localparam int            CW      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    owner_e        owner_reg, owner_next;
    logic          lane_reg, lane_next;
    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;

    logic grant_if;
    logic grant_ls;
    logic ls_lane;

    assign ls_lane = bus.ls_addr[2];

    // Grants are held low during reset so the macro sees no access while cpurst_n is low.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (cpurst_n) begin
            if (bus.if_req && (!bus.ls_req || starve_cnt_reg == CNT_MAX)) begin
                grant_if = 1'b1;
            end else if (bus.ls_req) begin
                grant_ls = 1'b1;
            end
        end
    end

    assign bus.if_gnt = grant_if;
    assign bus.ls_gnt = grant_ls;

    // State register: read owner, lane and starvation count.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            owner_reg      <= OWN_NONE;
            lane_reg       <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            owner_reg      <= owner_next;
            lane_reg       <= lane_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Next-state: capture who owns the read returning next cycle; writes return nothing.
    always_comb begin
        owner_next = OWN_NONE;
        lane_next  = 1'b0;
        if (grant_if) begin
            owner_next = OWN_IF;
        end else if (grant_ls && !bus.ls_we) begin
            owner_next = OWN_LS;
            lane_next  = ls_lane;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_if || !bus.if_req) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != CNT_MAX) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
        end
    end

    // Output decode: route macro read data to the registered owner, zero otherwise.
    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = 64'h0;
        bus.ls_rvalid = 1'b0;
        bus.ls_rdata  = 32'h0;
        case (owner_reg)
            OWN_IF: begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.ram_dout;
            end
            OWN_LS: begin
                bus.ls_rvalid = 1'b1;
                bus.ls_rdata  = lane_reg ? bus.ram_dout[63:32] : bus.ram_dout[31:0];
            end
            default: begin
            end
        endcase
    end

    // Per-lane chip select, byte enables and write data.
    logic        lane_cs  [2];
    logic [3:0]  lane_ben [2];
    logic [31:0] lane_din [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic ls_hit;
            assign ls_hit       = grant_ls && (ls_lane == 1'(gi));
            assign lane_cs[gi]  = grant_if || ls_hit;
            assign lane_ben[gi] = grant_if ? 4'hf : (ls_hit ? bus.ls_ben : 4'h0);
            assign lane_din[gi] = grant_ls ? bus.ls_wdata : 32'h0;
        end
    endgenerate

    assign bus.ram_csn0 = ~lane_cs[0];
    assign bus.ram_csn1 = ~lane_cs[1];
    assign bus.ram_wen  = ~(grant_ls && bus.ls_we);
    assign bus.ram_ben  = {lane_ben[1], lane_ben[0]};
    assign bus.ram_din  = {lane_din[1], lane_din[0]};
    assign bus.ram_addr = grant_if ? bus.if_addr[AW-1:0]
                        : grant_ls ? bus.ls_addr[AW+2:3]
                        : '0;

    logic unused_bits;
    assign unused_bits = ^{bus.if_addr[28:AW], bus.ls_addr[31:AW+3], bus.ls_addr[1:0]};

endmodule

// File: tb/tb_itcm_arb.sv
// Directed bench for itcm_arb: vector table for single accesses plus
// hand-written reset, starvation and reset-during-read sequences.
module tb_itcm_arb;
    logic clk;
    logic cpurst_n;
    int   checks;
    int   errors;

    itcm_arb_if #(.AW(16)) bus ();

    itcm_arb #(.AW(16), .STARVE_MAX(4)) dut (
        .clk      (clk),
        .cpurst_n (cpurst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [28:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [3:0]  ls_ben;
        logic [31:0] ls_wdata;
        logic [63:0] dout;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_csn0;
        logic        e_csn1;
        logic        e_wen;
        logic [15:0] e_addr;
        logic [7:0]  e_ben;
        logic [63:0] e_din;
        logic        e_if_rv;
        logic        e_ls_rv;
        logic [63:0] e_if_rd;
        logic [31:0] e_ls_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_ben   = '0;
        bus.ls_wdata = '0;
        bus.ram_dout = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Field order: if_req if_addr ls_req ls_we ls_addr ls_ben ls_wdata dout |
        //   if_gnt ls_gnt csn0 csn1 wen addr ben din | if_rv ls_rv if_rd ls_rd
        vecs[0] = '{1'b1, 29'h10, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 64'h1111_2222_3333_4444,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 8'hff, 64'h0,
                    1'b1, 1'b0, 64'h1111_2222_3333_4444, 32'h0};
        vecs[1] = '{1'b0, 29'h0, 1'b1, 1'b1, 32'h0000_0014, 4'b0011, 32'hdead_beef, 64'hffff_ffff_ffff_ffff,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 8'h30, 64'hdead_beef_dead_beef,
                    1'b0, 1'b0, 64'h0, 32'h0};
        vecs[2] = '{1'b0, 29'h0, 1'b1, 1'b0, 32'h0000_0014, 4'hf, 32'h0, 64'hcafe_f00d_1234_5678,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 8'hf0, 64'h0,
                    1'b0, 1'b1, 64'h0, 32'hcafe_f00d};
        vecs[3] = '{1'b0, 29'h0, 1'b1, 1'b0, 32'h0007_fff8, 4'hf, 32'h0, 64'h0123_4567_89ab_cdef,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hffff, 8'h0f, 64'h0,
                    1'b0, 1'b1, 64'h0, 32'h89ab_cdef};
        vecs[4] = '{1'b0, 29'h0, 1'b1, 1'b1, 32'h0000_0100, 4'b1000, 32'h1234_5678, 64'h5555_5555_5555_5555,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 8'h08, 64'h1234_5678_1234_5678,
                    1'b0, 1'b0, 64'h0, 32'h0};
        vecs[5] = '{1'b1, 29'h55, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 64'haaaa_bbbb_cccc_dddd,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 8'h00, 64'h0,
                    1'b0, 1'b1, 64'h0, 32'hcccc_dddd};
        vecs[6] = '{1'b0, 29'h77, 1'b0, 1'b1, 32'h0000_0044, 4'hf, 32'h9999_9999, 64'h7777_7777_7777_7777,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 64'h0,
                    1'b0, 1'b0, 64'h0, 32'h0};
        vecs[7] = '{1'b1, 29'h1fff_ffff, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 64'h8765_4321_0fed_cba9,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hffff, 8'hff, 64'h0,
                    1'b1, 1'b0, 64'h8765_4321_0fed_cba9, 32'h0};

        // Reset held with both requesters active: no access may leak out.
        idle_inputs();
        cpurst_n    = 1'b0;
        bus.if_req  = 1'b1;
        bus.ls_req  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_gnt", 64'(bus.if_gnt), 64'h0);
        chk("rst_ls_gnt", 64'(bus.ls_gnt), 64'h0);
        chk("rst_csn", 64'({bus.ram_csn0, bus.ram_csn1, bus.ram_wen}), 64'h7);
        chk("rst_rvalid", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'h0);
        chk("rst_rdata", 64'(bus.if_rdata | 64'(bus.ls_rdata)), 64'h0);
        $display("reset hold: if_gnt=%b ls_gnt=%b", bus.if_gnt, bus.ls_gnt);

        // Release with both requests held: LS for 4 cycles, fetch in cycle 4, repeat.
        @(negedge clk);
        cpurst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("starve_if_gnt_c%0d", c), 64'(bus.if_gnt), 64'(c == 4 || c == 9));
            chk($sformatf("starve_ls_gnt_c%0d", c), 64'(bus.ls_gnt), 64'(!(c == 4 || c == 9)));
            chk($sformatf("starve_if_rv_c%0d", c), 64'(bus.if_rvalid), 64'(c == 5));
            chk($sformatf("starve_ls_rv_c%0d", c), 64'(bus.ls_rvalid), 64'(c >= 1 && c != 5));
            $display("starve cycle %0d: if_gnt=%b ls_gnt=%b", c, bus.if_gnt, bus.ls_gnt);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            bus.if_req   = vecs[i].if_req;
            bus.if_addr  = vecs[i].if_addr;
            bus.ls_req   = vecs[i].ls_req;
            bus.ls_we    = vecs[i].ls_we;
            bus.ls_addr  = vecs[i].ls_addr;
            bus.ls_ben   = vecs[i].ls_ben;
            bus.ls_wdata = vecs[i].ls_wdata;
            bus.ram_dout = '0;
            #1;
            chk($sformatf("v%0d_if_gnt", i), 64'(bus.if_gnt), 64'(vecs[i].e_if_gnt));
            chk($sformatf("v%0d_ls_gnt", i), 64'(bus.ls_gnt), 64'(vecs[i].e_ls_gnt));
            chk($sformatf("v%0d_csn_wen", i), 64'({bus.ram_csn0, bus.ram_csn1, bus.ram_wen}),
                64'({vecs[i].e_csn0, vecs[i].e_csn1, vecs[i].e_wen}));
            chk($sformatf("v%0d_addr", i), 64'(bus.ram_addr), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d_ben", i), 64'(bus.ram_ben), 64'(vecs[i].e_ben));
            chk($sformatf("v%0d_din", i), bus.ram_din, vecs[i].e_din);
            @(negedge clk);
            idle_inputs();
            bus.ram_dout = vecs[i].dout;
            #1;
            chk($sformatf("v%0d_if_rvalid", i), 64'(bus.if_rvalid), 64'(vecs[i].e_if_rv));
            chk($sformatf("v%0d_ls_rvalid", i), 64'(bus.ls_rvalid), 64'(vecs[i].e_ls_rv));
            chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, vecs[i].e_if_rd);
            chk($sformatf("v%0d_ls_rdata", i), 64'(bus.ls_rdata), 64'(vecs[i].e_ls_rd));
            $display("vector %0d: gnt=%b%b addr=%h ben=%h rv=%b%b", i, bus.if_gnt, bus.ls_gnt,
                     bus.ram_addr, bus.ram_ben, bus.if_rvalid, bus.ls_rvalid);
            @(negedge clk);
        end

        // Reset asserted while an LS read is being granted: grant drops, nothing returns.
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h0000_0014;
        #1;
        chk("rstA_ls_gnt_before", 64'(bus.ls_gnt), 64'h1);
        #2;
        cpurst_n = 1'b0;
        #1;
        chk("rstA_ls_gnt_during", 64'(bus.ls_gnt), 64'h0);
        idle_inputs();
        bus.ram_dout = 64'h0bad_0bad_0bad_0bad;
        @(negedge clk);
        cpurst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rstA_ls_rvalid_after", 64'(bus.ls_rvalid), 64'h0);
        $display("reset during grant: ls_rvalid=%b", bus.ls_rvalid);

        // Reset asserted while the read data is returning: rvalid clears at once.
        @(negedge clk);
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h0000_0014;
        @(posedge clk);
        #1;
        idle_inputs();
        bus.ram_dout = 64'hfeed_face_0000_1111;
        #1;
        chk("rstB_ls_rvalid_pre", 64'(bus.ls_rvalid), 64'h1);
        chk("rstB_ls_rdata_pre", 64'(bus.ls_rdata), 64'hfeed_face);
        cpurst_n = 1'b0;
        #1;
        chk("rstB_ls_rvalid_rst", 64'(bus.ls_rvalid), 64'h0);
        chk("rstB_ls_rdata_rst", 64'(bus.ls_rdata), 64'h0);
        @(negedge clk);
        cpurst_n    = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 29'h3;
        #1;
        chk("rstB_if_gnt_release", 64'(bus.if_gnt), 64'h1);
        chk("rstB_addr_release", 64'(bus.ram_addr), 64'h3);
        @(negedge clk);
        idle_inputs();
        bus.ram_dout = 64'h0102_0304_0506_0708;
        #1;
        chk("rstB_if_rvalid", 64'(bus.if_rvalid), 64'h1);
        chk("rstB_if_rdata", bus.if_rdata, 64'h0102_0304_0506_0708);
        chk("rstB_ls_rvalid", 64'(bus.ls_rvalid), 64'h0);
        $display("reset during return: fetch after release rvalid=%b", bus.if_rvalid);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
